// File: rtl/udp_header_tx.sv
// udp_header_tx: prepends an 8-byte UDP header (checksum left at zero) to a
// byte-serial payload pulled from an FWFT FIFO, throttled by tx_ready.
module udp_header_tx #(
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic        clock,
  input  logic        sclr,
  input  logic        start,
  input  logic [15:0] payload_len,
  input  logic [15:0] BOARD_PORT,
  input  logic [15:0] PC_PORT,
  output logic        busy,
  output logic        err,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_rd,
  input  logic        tx_ready,
  output logic [7:0]  dataout,
  output logic        dataen,
  output logic        eop,
  output logic        done
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] len_q, len_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [7:0]  dataout_q, dataout_d;
  logic        dataen_q, dataen_d;
  logic        eop_q, eop_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  hdr_byte;

  // Header byte selected by the current index, MSB of each field first.
  always_comb begin
    hdr_byte = '0;
    case (idx_q)
      3'd0:    hdr_byte = src_q[15:8];
      3'd1:    hdr_byte = src_q[7:0];
      3'd2:    hdr_byte = dst_q[15:8];
      3'd3:    hdr_byte = dst_q[7:0];
      3'd4:    hdr_byte = udp_len_q[15:8];
      3'd5:    hdr_byte = udp_len_q[7:0];
      default: hdr_byte = '0;
    endcase
  end

  // Next-state, datapath and pop strobe.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    len_d     = len_q;
    src_d     = src_q;
    dst_d     = dst_q;
    udp_len_d = udp_len_q;
    dataout_d = dataout_q;
    dataen_d  = 1'b0;
    eop_d     = 1'b0;
    err_d     = 1'b0;
    done_d    = eop_q;
    pl_rd     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (payload_len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            len_d     = payload_len;
            src_d     = BOARD_PORT;
            dst_d     = PC_PORT;
            udp_len_d = payload_len + 16'd8;
            idx_d     = '0;
            state_d   = HDR;
          end
        end
      end
      HDR: begin
        if (tx_ready) begin
          dataen_d  = 1'b1;
          dataout_d = hdr_byte;
          idx_d     = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            rem_d = len_q;
            if (len_q == '0) begin
              eop_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = PAY;
            end
          end
        end
      end
      PAY: begin
        if (tx_ready && pl_valid) begin
          // Pop is suppressed under sclr so an aborted frame leaves the FIFO intact.
          pl_rd     = ~sclr;
          dataen_d  = 1'b1;
          dataout_d = pl_data;
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            eop_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      udp_len_q <= '0;
      dataout_q <= '0;
      dataen_q  <= 1'b0;
      eop_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      udp_len_q <= udp_len_d;
      dataout_q <= dataout_d;
      dataen_q  <= dataen_d;
      eop_q     <= eop_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // busy spans the eop cycle too, so it falls together with done.
  assign busy    = (state_q != IDLE) || eop_q;
  assign err     = err_q;
  assign dataout = dataout_q;
  assign dataen  = dataen_q;
  assign eop     = eop_q;
  assign done    = done_q;

endmodule

// File: tb/tb_udp_header_tx.sv
// Directed bench for udp_header_tx: table of frame vectors plus reset/abort sequences.
module tb_udp_header_tx;

  logic        clock = 1'b0;
  logic        sclr;
  logic        start;
  logic [15:0] payload_len;
  logic [15:0] BOARD_PORT;
  logic [15:0] PC_PORT;
  logic        busy;
  logic        err;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_rd;
  logic        tx_ready;
  logic [7:0]  dataout;
  logic        dataen;
  logic        eop;
  logic        done;

  always #5 clock = ~clock;

  udp_header_tx #(.MAX_PAYLOAD(1472)) dut (
    .clock      (clock),
    .sclr       (sclr),
    .start      (start),
    .payload_len(payload_len),
    .BOARD_PORT (BOARD_PORT),
    .PC_PORT    (PC_PORT),
    .busy       (busy),
    .err        (err),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_rd      (pl_rd),
    .tx_ready   (tx_ready),
    .dataout    (dataout),
    .dataen     (dataen),
    .eop        (eop),
    .done       (done)
  );

  typedef struct {
    logic [15:0] board;
    logic [15:0] pc;
    logic [15:0] plen;
    int          mode;     // 0: always ready, 1: tx_ready toggles + FIFO gap
    bit          inject;   // drive a competing start mid-header
    bit          exp_err;
    logic [7:0]  len_hi;   // hand-computed udp_len bytes
    logic [7:0]  len_lo;
  } vec_t;

  vec_t        vecs[7];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  fifo[$];
  int          pops;
  int          blk_cnt;
  bit          blk_started;
  bit          rd_empty_seen;

  function automatic logic [7:0] pay_byte(int i);
    case (i)
      0:       return 8'hDE;
      1:       return 8'hAD;
      2:       return 8'hBE;
      3:       return 8'hEF;
      default: return 8'((i * 37 + 5) & 255);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_fifo_view();
    pl_valid = (fifo.size() > 0) && (blk_cnt == 0);
    pl_data  = pl_valid ? fifo[0] : 8'h00;
  endtask

  // One clock: settle inputs, observe pop strobe, take the edge, then pop and sample.
  task automatic step();
    bit pop;
    update_fifo_view();
    #1;
    if (pl_rd && !pl_valid) rd_empty_seen = 1'b1;
    pop = pl_rd;
    @(posedge clock);
    #1;
    if (pop && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    if (blk_cnt > 0) blk_cnt--;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_dataen"}, dataen, 0);
    check({tag, "_eop"}, eop, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dataout"}, dataout, 0);
    check({tag, "_pl_rd"}, pl_rd, 0);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] exp_bytes[$];
    logic [7:0] got[$];
    int  nexp;
    int  npred;
    int  eop_cnt;
    int  eop_at;
    int  eop_k;
    int  done_k;
    int  stall_bad;
    int  mism;
    int  quiet_bad;
    bit  adv;
    bit  busy_at_done;

    fifo.delete();
    pops = 0;
    blk_cnt = 0;
    blk_started = 1'b0;
    rd_empty_seen = 1'b0;
    exp_bytes.push_back(v.board[15:8]);
    exp_bytes.push_back(v.board[7:0]);
    exp_bytes.push_back(v.pc[15:8]);
    exp_bytes.push_back(v.pc[7:0]);
    exp_bytes.push_back(v.len_hi);
    exp_bytes.push_back(v.len_lo);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h00);
    if (!v.exp_err) begin
      for (int i = 0; i < int'(v.plen); i++) begin
        exp_bytes.push_back(pay_byte(i));
        fifo.push_back(pay_byte(i));
      end
    end
    nexp = exp_bytes.size();

    start       = 1'b1;
    payload_len = v.plen;
    BOARD_PORT  = v.board;
    PC_PORT     = v.pc;
    tx_ready    = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_err"}, err, v.exp_err);
    check({tag, "_busy_start"}, busy, !v.exp_err);

    if (v.exp_err) begin
      quiet_bad = 0;
      for (int k = 0; k < 5; k++) begin
        step();
        if (dataen || busy || eop || done) quiet_bad++;
        if (err) quiet_bad++;
      end
      check({tag, "_quiet"}, quiet_bad, 0);
      check({tag, "_no_pop"}, pops, 0);
      return;
    end

    npred = 0;
    eop_cnt = 0;
    eop_at = -1;
    eop_k = -100;
    done_k = -1;
    stall_bad = 0;
    busy_at_done = 1'b1;
    for (int k = 0; k < nexp * 3 + 40 && done_k < 0; k++) begin
      tx_ready = (v.mode == 0) ? 1'b1 : (k % 2 == 0);
      if (v.mode == 1 && pops == 2 && !blk_started) begin
        blk_cnt = 3;
        blk_started = 1'b1;
      end
      if (v.inject && k == 3) begin
        start       = 1'b1;
        payload_len = 16'd9;
        BOARD_PORT  = 16'hFFFF;
        PC_PORT     = 16'hEEEE;
      end
      update_fifo_view();
      adv = (npred < nexp) && tx_ready && (npred < 8 || pl_valid);
      step();
      start = 1'b0;
      if (dataen !== adv) stall_bad++;
      if (eop && !dataen) stall_bad++;
      if (adv) npred++;
      if (dataen) begin
        got.push_back(dataout);
        if (eop) begin
          eop_cnt++;
          eop_at = got.size();
          eop_k = k;
        end
      end
      if (done) begin
        done_k = k;
        busy_at_done = busy;
      end
    end

    check({tag, "_done_seen"}, (done_k >= 0), 1);
    check({tag, "_nbytes"}, got.size(), nexp);
    mism = 0;
    for (int i = 0; i < nexp && i < got.size(); i++) begin
      if (got[i] !== exp_bytes[i]) begin
        if (mism == 0)
          $display("FAIL %s_byte%0d: got %02h expected %02h", tag, i, got[i], exp_bytes[i]);
        mism++;
      end
    end
    total++;
    if (mism != 0) bad++;
    check({tag, "_eop_cnt"}, eop_cnt, 1);
    check({tag, "_eop_pos"}, eop_at, nexp);
    check({tag, "_done_lat"}, done_k - eop_k, 1);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
    check({tag, "_dataen_pattern"}, stall_bad, 0);
    check({tag, "_pops"}, pops, int'(v.plen));
    check({tag, "_rd_empty"}, rd_empty_seen, 0);
  endtask

  initial begin
    int cnt;
    int quiet_bad;

    vecs[0] = '{16'h1234, 16'hABCD, 16'd4,    0, 1'b0, 1'b0, 8'h00, 8'h0C};
    vecs[1] = '{16'h0050, 16'h1F90, 16'd0,    0, 1'b0, 1'b0, 8'h00, 8'h08};
    vecs[2] = '{16'h1234, 16'hABCD, 16'd4,    1, 1'b0, 1'b0, 8'h00, 8'h0C};
    vecs[3] = '{16'h0001, 16'h0002, 16'd1473, 0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[4] = '{16'hFFFF, 16'h0000, 16'd1472, 0, 1'b0, 1'b0, 8'h05, 8'hC8};
    vecs[5] = '{16'h0A0B, 16'h0C0D, 16'd1,    1, 1'b0, 1'b0, 8'h00, 8'h09};
    vecs[6] = '{16'h4321, 16'h8765, 16'd4,    0, 1'b1, 1'b0, 8'h00, 8'h0C};

    sclr = 1'b1;
    start = 1'b0;
    payload_len = '0;
    BOARD_PORT = '0;
    PC_PORT = '0;
    tx_ready = 1'b0;
    pops = 0;
    blk_cnt = 0;
    blk_started = 1'b0;
    rd_empty_seen = 1'b0;
    update_fifo_view();
    repeat (3) step();
    check_all_zero("reset");
    sclr = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      step();
    end

    // Abort after the fifth header byte, then a clean frame.
    fifo.delete();
    for (int i = 0; i < 4; i++) fifo.push_back(pay_byte(i));
    pops = 0;
    start = 1'b1;
    payload_len = 16'd4;
    BOARD_PORT = 16'h1234;
    PC_PORT = 16'hABCD;
    tx_ready = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 5; k++) begin
      step();
      if (dataen) cnt++;
    end
    check("abort_hdr_bytes", cnt, 5);
    check("abort_5th_byte", dataout, 8'h00);
    sclr = 1'b1;
    step();
    check_all_zero("abort");
    sclr = 1'b0;
    quiet_bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (dataen || eop || done || busy) quiet_bad++;
    end
    check("abort_quiet", quiet_bad, 0);
    check("abort_no_pop", pops, 0);
    run_frame(vecs[0], "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
